// File: rtl/dot_prod_feeder_if.sv
// Operand stream, accumulator link and result signals of the dot-product feeder.
// The master drives operands, control and accumulator feedback; the slave is the feeder.
interface dot_prod_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   // Handshake: a pair transfers on every rising clk edge where in_valid && in_ready;
   // in_valid may rise without waiting for in_ready, and a/b must hold while in_valid waits.
   logic                  start;
   logic                  abort;
   logic [LEN_WIDTH-1:0]  vec_len;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a_data;
   logic [DATA_WIDTH-1:0] b_data;
   logic [DATA_WIDTH-1:0] accum_fb;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  stg_en;
   logic                  busy;
   logic [DATA_WIDTH-1:0] result;
   logic                  result_valid;
   logic                  overflow;

   modport master (
      output start, abort, vec_len, in_valid, a_data, b_data, accum_fb,
      input  in_ready, acc_data, stg_en, busy, result, result_valid, overflow
   );

   modport slave (
      input  start, abort, vec_len, in_valid, a_data, b_data, accum_fb,
      output in_ready, acc_data, stg_en, busy, result, result_valid, overflow
   );
endinterface

// File: rtl/dot_prod_feeder.sv
// Feeds a stream of a*b products into an external accumulator and captures the
// accumulated dot product once the last product has landed.
module dot_prod_feeder #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    LEN_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   dot_prod_feeder_if.slave  ctl_io,
   output logic [1:0]        state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [LEN_WIDTH-1:0]  count_q, count_d;
   logic [DATA_WIDTH-1:0] prod_q, prod_d;
   logic                  prod_vld_q, prod_vld_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  result_valid_q, result_valid_d;
   logic                  overflow_q, overflow_d;

   logic                    beat;
   logic [2*DATA_WIDTH-1:0] full_prod;
   logic                    prod_hi_nz;
   logic [DATA_WIDTH-1:0]   addend;
   logic [DATA_WIDTH:0]     sum_w;
   logic                    in_ready_w;
   logic                    stg_en_w;

   // Output decode depends only on registered state.
   assign in_ready_w = (state_q == S_RUN);
   assign stg_en_w   = (state_q != S_IDLE);
   assign beat       = ctl_io.in_valid & in_ready_w;

   assign full_prod  = {{DATA_WIDTH{1'b0}}, ctl_io.a_data} * {{DATA_WIDTH{1'b0}}, ctl_io.b_data};
   assign prod_hi_nz = |full_prod[2*DATA_WIDTH-1:DATA_WIDTH];

   assign addend = prod_vld_q ? prod_q : '0;
   assign sum_w  = {1'b0, ctl_io.accum_fb} + {1'b0, addend};

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      prod_d         = prod_q;
      prod_vld_d     = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      overflow_d     = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (ctl_io.start) begin
               if (ctl_io.vec_len != '0) begin
                  count_d    = ctl_io.vec_len;
                  overflow_d = 1'b0;
                  state_d    = S_RUN;
               end else begin
                  result_d       = ACCUM_INIT;
                  result_valid_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (beat) begin
               prod_d     = full_prod[DATA_WIDTH-1:0];
               prod_vld_d = 1'b1;
               count_d    = count_q - 1'b1;
               if (count_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            result_d       = ctl_io.accum_fb;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (beat && prod_hi_nz) begin
         overflow_d = 1'b1;
      end
      if (stg_en_w && sum_w[DATA_WIDTH]) begin
         overflow_d = 1'b1;
      end

      // Abort wins over every transition and suppresses any pending result.
      if (ctl_io.abort) begin
         state_d        = S_IDLE;
         prod_vld_d     = 1'b0;
         result_d       = result_q;
         result_valid_d = 1'b0;
         overflow_d     = overflow_q | (beat & prod_hi_nz) | (stg_en_w & sum_w[DATA_WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         count_q        <= '0;
         prod_q         <= '0;
         prod_vld_q     <= 1'b0;
         result_q       <= ACCUM_INIT;
         result_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         prod_q         <= prod_d;
         prod_vld_q     <= prod_vld_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   assign ctl_io.in_ready     = in_ready_w;
   assign ctl_io.stg_en       = stg_en_w;
   assign ctl_io.busy         = stg_en_w;
   assign ctl_io.acc_data     = sum_w[DATA_WIDTH-1:0];
   assign ctl_io.result       = result_q;
   assign ctl_io.result_valid = result_valid_q;
   assign ctl_io.overflow     = overflow_q;
   assign state_o             = state_q;

   a_rv_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
      result_valid_q |-> (state_q == S_IDLE));
   a_run_count : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == S_RUN) |-> (count_q != '0));

endmodule
